lane_dly_seq: RTL and testbench

LANE_DLY_SEQ -- requirements
Module: lane_dly_seq

---
 rtl/lane_dly_seq_if.sv | 25 ++
 rtl/lane_dly_seq.sv | 169 ++++++++++++++++
 tb/tb_lane_dly_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/lane_dly_seq_if.sv
// Command handshake bundle for the lane delay-line sequencer.
// Master issues one delay-line command; slave accepts on VALID && READY.
interface lane_dly_seq_if;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [1:0] CMD_OP;
    logic       CMD_SEL;
    logic [7:0] CMD_TAPS;

    modport master (
        output CMD_VALID,
        output CMD_OP,
        output CMD_SEL,
        output CMD_TAPS,
        input  CMD_READY
    );

    modport slave (
        input  CMD_VALID,
        input  CMD_OP,
        input  CMD_SEL,
        input  CMD_TAPS,
        output CMD_READY
    );
endinterface

// File: rtl/lane_dly_seq.sv
// Lane delay-line sequencer: steps or reloads the RX/TX delay line taps
// and tracks the resulting tap positions.
module lane_dly_seq #(
    parameter int unsigned MOVE_GAP  = 4,
    parameter int unsigned PAUSE_CYC = 3,
    parameter logic [7:0]  INIT_TAP  = 8'd1
) (
    input  logic                FAB_CLK,
    input  logic                ARST_N,
    lane_dly_seq_if.slave       cmd,
    input  logic                RX_DELAY_LINE_OUT_OF_RANGE,
    input  logic                TX_DELAY_LINE_OUT_OF_RANGE,
    output logic                DELAY_LINE_SEL,
    output logic                DELAY_LINE_LOAD,
    output logic                DELAY_LINE_DIRECTION,
    output logic                DELAY_LINE_MOVE,
    output logic                HS_IO_CLK_PAUSE,
    output logic                DONE,
    output logic                ERR,
    output logic                BUSY,
    output logic [7:0]          TAP_RX,
    output logic [7:0]          TAP_TX
);

    typedef enum logic [2:0] {
        IDLE, SETUP, PRE_PAUSE, LOAD,
        POST_PAUSE, MOVE, GAP, FINISH
    } state_t;

    localparam logic [1:0] OP_INC  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    localparam logic [3:0] GAP_LAST   = 4'(MOVE_GAP - 2);
    localparam logic [3:0] PAUSE_LAST = 4'(PAUSE_CYC - 1);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] op_q;
    logic       sel_q;
    logic [7:0] cnt_q;
    logic [3:0] tmr_q;
    logic       err_q;
    logic       rdy_q;
    logic       set_err;
    logic       accept;
    logic       inc;
    logic       at_lim;
    logic       oor;
    logic [7:0] tap_sel;

    assign accept  = (state_q == IDLE) && rdy_q && cmd.CMD_VALID;
    assign inc     = (op_q == OP_INC);
    assign tap_sel = sel_q ? TAP_TX : TAP_RX;
    assign oor     = sel_q ? TX_DELAY_LINE_OUT_OF_RANGE
                           : RX_DELAY_LINE_OUT_OF_RANGE;
    assign at_lim  = inc ? (tap_sel == 8'hFF) : (tap_sel == 8'h00);

    assign cmd.CMD_READY = (state_q == IDLE) && rdy_q;

    // State register; reset discards any command in flight.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decisions and state-decoded lane controls.
    always_comb begin
        state_d              = state_q;
        set_err              = 1'b0;
        BUSY                 = (state_q != IDLE);
        DELAY_LINE_SEL       = (state_q != IDLE) && sel_q;
        DELAY_LINE_DIRECTION = (state_q != IDLE) && inc;
        DELAY_LINE_MOVE      = (state_q == MOVE);
        DELAY_LINE_LOAD      = (state_q == LOAD);
        HS_IO_CLK_PAUSE      = (state_q == PRE_PAUSE) ||
                               (state_q == LOAD) ||
                               (state_q == POST_PAUSE);
        DONE                 = (state_q == FINISH);
        ERR                  = (state_q == FINISH) && err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = SETUP;
            end
            SETUP: begin
                if (op_q == OP_LOAD) begin
                    state_d = PRE_PAUSE;
                end else if (op_q == OP_ILL) begin
                    state_d = FINISH;
                    set_err = 1'b1;
                end else if (cnt_q == 8'd0) begin
                    state_d = FINISH;
                end else if (at_lim) begin
                    state_d = FINISH;
                    set_err = 1'b1;
                end else begin
                    state_d = MOVE;
                end
            end
            PRE_PAUSE: begin
                if (tmr_q == PAUSE_LAST) state_d = LOAD;
            end
            LOAD: begin
                state_d = POST_PAUSE;
            end
            POST_PAUSE: begin
                if (tmr_q == PAUSE_LAST) state_d = FINISH;
            end
            MOVE: begin
                state_d = GAP;
            end
            GAP: begin
                if (tmr_q == GAP_LAST) begin
                    if (oor) begin
                        state_d = FINISH;
                        set_err = 1'b1;
                    end else if (cnt_q == 8'd0) begin
                        state_d = FINISH;
                    end else if (at_lim) begin
                        state_d = FINISH;
                        set_err = 1'b1;
                    end else begin
                        state_d = MOVE;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
        endcase
    end

    // Command latch, timers, error flag and tap tracking.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            op_q   <= 2'b00;
            sel_q  <= 1'b0;
            cnt_q  <= 8'd0;
            tmr_q  <= 4'd0;
            err_q  <= 1'b0;
            rdy_q  <= 1'b0;
            TAP_RX <= INIT_TAP;
            TAP_TX <= INIT_TAP;
        end else begin
            rdy_q <= 1'b1;
            tmr_q <= (state_d == state_q) ? tmr_q + 4'd1 : 4'd0;
            if (accept) begin
                op_q  <= cmd.CMD_OP;
                sel_q <= cmd.CMD_SEL;
                cnt_q <= cmd.CMD_TAPS;
                err_q <= 1'b0;
            end
            if (set_err) err_q <= 1'b1;
            if (state_q == MOVE) begin
                cnt_q <= cnt_q - 8'd1;
                if (sel_q) TAP_TX <= inc ? TAP_TX + 8'd1 : TAP_TX - 8'd1;
                else       TAP_RX <= inc ? TAP_RX + 8'd1 : TAP_RX - 8'd1;
            end
            if (state_q == LOAD) begin
                if (sel_q) TAP_TX <= INIT_TAP;
                else       TAP_RX <= INIT_TAP;
            end
        end
    end

endmodule

// File: tb/tb_lane_dly_seq.sv
// Directed bench for lane_dly_seq: command table plus
// reset-in-flight sequences.
module tb_lane_dly_seq;

    typedef struct {
        logic [1:0] op;
        logic       sel;
        logic [7:0] taps;
        int         oor_at;
        int         moves;
        int         pauses;
        int         load_at;
        int         done_at;
        logic       err;
        logic [7:0] rx;
        logic [7:0] tx;
    } vec_t;

    logic       FAB_CLK = 1'b0;
    logic       ARST_N;
    logic       rx_oor;
    logic       tx_oor;
    logic       dl_sel, dl_load, dl_dir, dl_move, pause;
    logic       done, err, busy;
    logic [7:0] tap_rx, tap_tx;

    int n_pass = 0;
    int n_chk  = 0;

    lane_dly_seq_if cmd_if ();

    lane_dly_seq dut (
        .FAB_CLK                    (FAB_CLK),
        .ARST_N                     (ARST_N),
        .cmd                        (cmd_if.slave),
        .RX_DELAY_LINE_OUT_OF_RANGE (rx_oor),
        .TX_DELAY_LINE_OUT_OF_RANGE (tx_oor),
        .DELAY_LINE_SEL             (dl_sel),
        .DELAY_LINE_LOAD            (dl_load),
        .DELAY_LINE_DIRECTION       (dl_dir),
        .DELAY_LINE_MOVE            (dl_move),
        .HS_IO_CLK_PAUSE            (pause),
        .DONE                       (done),
        .ERR                        (err),
        .BUSY                       (busy),
        .TAP_RX                     (tap_rx),
        .TAP_TX                     (tap_tx)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic accept(input logic [1:0] op, input logic sel,
                          input logic [7:0] taps);
        int w;
        w = 0;
        @(negedge FAB_CLK);
        while (!cmd_if.CMD_READY && w < 10) begin
            @(negedge FAB_CLK);
            w++;
        end
        chk("ready_before_cmd", int'(cmd_if.CMD_READY), 1);
        cmd_if.CMD_VALID = 1'b1;
        cmd_if.CMD_OP    = op;
        cmd_if.CMD_SEL   = sel;
        cmd_if.CMD_TAPS  = taps;
        @(posedge FAB_CLK);
        #1;
        cmd_if.CMD_VALID = 1'b0;
        cmd_if.CMD_OP    = 2'($urandom);
        cmd_if.CMD_SEL   = 1'($urandom);
        cmd_if.CMD_TAPS  = 8'($urandom);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int nmove, npause, load_k, done_k, bad_ctl, bad_sp, prev;
        logic err_s;
        string p;
        p = $sformatf("v%0d", idx);
        nmove = 0; npause = 0; load_k = 0; done_k = 0;
        bad_ctl = 0; bad_sp = 0; prev = 0; err_s = 1'b0;
        if (v.oor_at == 0) begin
            if (v.sel) tx_oor = 1'b1;
            else       rx_oor = 1'b1;
        end
        accept(v.op, v.sel, v.taps);
        for (int k = 1; k <= 2000; k++) begin
            @(negedge FAB_CLK);
            if (busy && (dl_sel != v.sel || dl_dir != (v.op == 2'b00)))
                bad_ctl++;
            if (dl_move && dl_load) bad_ctl++;
            if (pause && v.op != 2'b10) bad_ctl++;
            if (dl_load && !pause) bad_ctl++;
            if (err && !done) bad_ctl++;
            if (pause) npause++;
            if (dl_load) load_k = k;
            if (dl_move) begin
                nmove++;
                if (prev != 0 && k - prev != 4) bad_sp++;
                prev = k;
                if (nmove == v.oor_at) begin
                    if (v.sel) tx_oor = 1'b1;
                    else       rx_oor = 1'b1;
                end
            end
            if (done) begin
                done_k = k;
                err_s  = err;
                break;
            end
        end
        chk({p, "_done_at"}, done_k, v.done_at);
        chk({p, "_err"}, int'(err_s), int'(v.err));
        chk({p, "_moves"}, nmove, v.moves);
        chk({p, "_pauses"}, npause, v.pauses);
        chk({p, "_load_at"}, load_k, v.load_at);
        chk({p, "_ctl"}, bad_ctl, 0);
        chk({p, "_spacing"}, bad_sp, 0);
        chk({p, "_tap_rx"}, int'(tap_rx), int'(v.rx));
        chk({p, "_tap_tx"}, int'(tap_tx), int'(v.tx));
        @(negedge FAB_CLK);
        chk({p, "_idle_after"}, int'({done, cmd_if.CMD_READY}), 1);
        rx_oor = 1'b0;
        tx_oor = 1'b0;
    endtask

    task automatic release_rst(input string nm);
        int nd;
        repeat (2) @(negedge FAB_CLK);
        ARST_N = 1'b1;
        #1;
        chk({nm, "_ready_in_rst_rel"}, int'(cmd_if.CMD_READY), 0);
        @(negedge FAB_CLK);
        chk({nm, "_ready_after_edge"}, int'(cmd_if.CMD_READY), 1);
        nd = 0;
        repeat (20) begin
            @(negedge FAB_CLK);
            if (done || busy) nd++;
        end
        chk({nm, "_no_done"}, nd, 0);
    endtask

    vec_t tv[16];

    initial begin
        tv[0]  = '{2'b00, 1'b1, 8'd3,   -1, 3,   0, 0, 14,   1'b0, 8'd1,   8'd4};
        tv[1]  = '{2'b10, 1'b0, 8'd9,   -1, 0,   7, 5, 9,    1'b0, 8'd1,   8'd4};
        tv[2]  = '{2'b01, 1'b0, 8'd5,   -1, 1,   0, 0, 6,    1'b1, 8'd0,   8'd4};
        tv[3]  = '{2'b11, 1'b0, 8'd7,   -1, 0,   0, 0, 2,    1'b1, 8'd0,   8'd4};
        tv[4]  = '{2'b00, 1'b1, 8'd0,   -1, 0,   0, 0, 2,    1'b0, 8'd0,   8'd4};
        tv[5]  = '{2'b01, 1'b1, 8'd2,   -1, 2,   0, 0, 10,   1'b0, 8'd0,   8'd2};
        tv[6]  = '{2'b00, 1'b0, 8'd1,   -1, 1,   0, 0, 6,    1'b0, 8'd1,   8'd2};
        tv[7]  = '{2'b10, 1'b1, 8'd0,   -1, 0,   7, 5, 9,    1'b0, 8'd1,   8'd1};
        tv[8]  = '{2'b00, 1'b1, 8'd10,   2, 2,   0, 0, 10,   1'b1, 8'd1,   8'd3};
        tv[9]  = '{2'b01, 1'b1, 8'd3,   -1, 3,   0, 0, 14,   1'b0, 8'd1,   8'd0};
        tv[10] = '{2'b01, 1'b1, 8'd1,   -1, 0,   0, 0, 2,    1'b1, 8'd1,   8'd0};
        tv[11] = '{2'b00, 1'b0, 8'd255, -1, 254, 0, 0, 1018, 1'b1, 8'd255, 8'd0};
        tv[12] = '{2'b00, 1'b0, 8'd1,   -1, 0,   0, 0, 2,    1'b1, 8'd255, 8'd0};
        tv[13] = '{2'b10, 1'b0, 8'd4,   -1, 0,   7, 5, 9,    1'b0, 8'd1,   8'd0};
        tv[14] = '{2'b11, 1'b1, 8'd0,   -1, 0,   0, 0, 2,    1'b1, 8'd1,   8'd0};
        tv[15] = '{2'b00, 1'b0, 8'd2,    0, 1,   0, 0, 6,    1'b1, 8'd2,   8'd0};

        ARST_N           = 1'b0;
        rx_oor           = 1'b0;
        tx_oor           = 1'b0;
        cmd_if.CMD_VALID = 1'b0;
        cmd_if.CMD_OP    = 2'b00;
        cmd_if.CMD_SEL   = 1'b0;
        cmd_if.CMD_TAPS  = 8'd0;

        #12;
        chk("rst_ready", int'(cmd_if.CMD_READY), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_strobes", int'({dl_move, dl_load, pause, done, err}), 0);
        chk("rst_sel_dir", int'({dl_sel, dl_dir}), 0);
        chk("rst_tap_rx", int'(tap_rx), 1);
        chk("rst_tap_tx", int'(tap_tx), 1);
        @(negedge FAB_CLK);
        ARST_N = 1'b1;
        #1;
        chk("rel_ready_pre_edge", int'(cmd_if.CMD_READY), 0);
        @(negedge FAB_CLK);
        chk("rel_ready_post_edge", int'(cmd_if.CMD_READY), 1);

        for (int i = 0; i < 16; i++) run_vec(i, tv[i]);

        // Reset in the second GAP of a TX increment (TX 0 -> 2).
        accept(2'b00, 1'b1, 8'd5);
        repeat (6) @(negedge FAB_CLK);
        chk("rA_move_k6", int'(dl_move), 1);
        @(negedge FAB_CLK);
        chk("rA_gap_tap_tx", int'(tap_tx), 2);
        chk("rA_gap_busy", int'(busy), 1);
        #1 ARST_N = 1'b0;
        #1;
        chk("rA_busy", int'(busy), 0);
        chk("rA_strobes", int'({dl_move, dl_load, pause, done}), 0);
        chk("rA_sel_dir", int'({dl_sel, dl_dir}), 0);
        chk("rA_tap_tx", int'(tap_tx), 1);
        chk("rA_tap_rx", int'(tap_rx), 1);
        release_rst("rA");

        // Reset while MOVE is high.
        accept(2'b00, 1'b0, 8'd3);
        repeat (2) @(negedge FAB_CLK);
        chk("rB_move_before", int'(dl_move), 1);
        #1 ARST_N = 1'b0;
        #1;
        chk("rB_move_after", int'({dl_move, dl_dir}), 0);
        chk("rB_tap_rx", int'(tap_rx), 1);
        release_rst("rB");

        // Reset while the clock pause is held before a load.
        accept(2'b10, 1'b1, 8'd0);
        repeat (3) @(negedge FAB_CLK);
        chk("rC_pause_before", int'(pause), 1);
        #1 ARST_N = 1'b0;
        #1;
        chk("rC_pause_after", int'({pause, dl_load, dl_sel}), 0);
        release_rst("rC");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
